// File: rtl/fifo_stream_pkg.sv
// Shared constants for the FIFO read-side stream adapter.
package fifo_stream_pkg;
  localparam int WORD_COUNT_WIDTH  = 32;
  localparam int FIFO_READ_LATENCY = 1;
  localparam int MIN_BUFFER_DEPTH  = 2;
endpackage

// File: rtl/stream_register_buffer.sv
// Small register FIFO: push at tail, pop at head, head word always visible.
module stream_register_buffer
  import fifo_stream_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 3
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [WIDTH-1:0]             head_data
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [PW-1:0]               head, tail;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
  endfunction

  // Entries are cleared on reset so the head word reads as zero afterwards.
  always_ff @(posedge clock) begin
    if (reset) begin
      mem   <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[tail] <= push_data;
        tail      <= wrap_inc(tail);
      end
      if (pop) head <= wrap_inc(head);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head_data = mem[head];
endmodule

// File: rtl/fifo_stream_reader.sv
// Read adapter for a non-FWFT FIFO: credit-based read issue into a register buffer.
// Optional accepted-word counter enabled by FIFO_STREAM_READER_WORD_COUNT_EN.
module fifo_stream_reader
  import fifo_stream_pkg::*;
#(
  parameter int DATA_WIDTH   = 16,
  parameter int BUFFER_DEPTH = 3
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        fifo_empty,
  input  logic [DATA_WIDTH-1:0]       fifo_read_data,
  input  logic                        fifo_read_data_valid,
  output logic                        fifo_read_enable,
  output logic [DATA_WIDTH-1:0]       stream_data,
  output logic                        stream_valid,
  input  logic                        stream_ready,
  output logic                        protocol_error,
  output logic [WORD_COUNT_WIDTH-1:0] words_delivered
);
  localparam int CW = $clog2(BUFFER_DEPTH+1);

  if (BUFFER_DEPTH < MIN_BUFFER_DEPTH) begin : g_depth_check
    $error("fifo_stream_reader: BUFFER_DEPTH below MIN_BUFFER_DEPTH");
  end
  if (FIFO_READ_LATENCY != 1) begin : g_latency_check
    $error("fifo_stream_reader: only a one-cycle FIFO read latency is supported");
  end

  logic [CW-1:0] count;
  logic [CW:0]   credit_used;
  logic          in_flight, post_reset, push, pop;

  // Credits count both buffered words and the one still returning from the FIFO,
  // so a push can never land in a full buffer and stream_ready never gates reads.
  assign credit_used      = {1'b0, count} + (CW+1)'(in_flight);
  assign fifo_read_enable = !reset && !fifo_empty && (credit_used < (CW+1)'(BUFFER_DEPTH));
  assign push             = fifo_read_data_valid && in_flight;
  assign stream_valid     = (count != '0);
  assign pop              = stream_valid && stream_ready;

  stream_register_buffer #(.WIDTH(DATA_WIDTH), .DEPTH(BUFFER_DEPTH)) u_buffer (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (fifo_read_data),
    .pop       (pop),
    .count     (count),
    .head_data (stream_data)
  );

  // A stray word in the first cycle after reset belongs to a read issued before it.
  always_ff @(posedge clock) begin
    if (reset) begin
      in_flight      <= 1'b0;
      post_reset     <= 1'b1;
      protocol_error <= 1'b0;
    end else begin
      in_flight  <= fifo_read_enable;
      post_reset <= 1'b0;
      if ((fifo_read_data_valid && !in_flight && !post_reset) ||
          (in_flight && !fifo_read_data_valid))
        protocol_error <= 1'b1;
    end
  end

`ifdef FIFO_STREAM_READER_WORD_COUNT_EN
  logic [WORD_COUNT_WIDTH-1:0] word_count;
  always_ff @(posedge clock) begin
    if (reset)    word_count <= '0;
    else if (pop) word_count <= word_count + WORD_COUNT_WIDTH'(1);
  end
  assign words_delivered = word_count;
`else
  assign words_delivered = '0;
`endif
endmodule
